uart_frame_rx: RTL
==================

Name: uart_frame_rx

Overview:
- Parametrised serial frame receiver/checker. Successor to the fixed 4-bit odd-parity frame checker.
- Generalised in data width, parity mode (none/odd/even) and stop-bit count.
- Adds a data output and separate parity and framing error flags, with optional break detection.
- Sits directly on the 1-bit line input. Line rate is one bit per clock, with no oversampling; an upstream sampler or synchroniser provides this.

Parameters:
DATA_BITS, 8, number of data bits per frame, legal range 1..16, sent LSB first
PARITY_MODE, 1, 0 = no parity bit, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
signal  input  1  serial line, idle high, one bit sampled per rising edge
data  output  DATA_BITS  last completed frame payload, bit 0 = first data bit received
valid  output  1  one-cycle pulse: frame complete, parity ok, all stop bits 1
parity_error  output  1  one-cycle pulse: stop bits ok, parity mismatch
frame_error  output  1  one-cycle pulse: at least one stop bit sampled 0
break_det  output  1  one-cycle pulse: break detected (optional feature only; tied 0 otherwise)

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high. While reset is high:
  - state -> IDLE
  - all outputs 0, data 0
  - counters cleared
- Reset asserted mid-frame aborts the frame. No flag is produced for the aborted frame.
- All outputs are registered. Each flag is high for exactly one cycle, on the cycle following the edge that samples the final stop bit.
- States:
  - IDLE: sample signal=0 -> START_SEEN handling. The start bit is consumed on this edge. Clear the shift register and bit counter, then go to DATA. Sample signal=1 -> stay in IDLE.
  - DATA: shift in one bit per edge, LSB first. After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else to STOP.
  - PARITY: capture one bit, then go to STOP.
  - STOP: sample STOP_BITS bits. Any 0 among them marks a framing fault.
    - On the last stop sample with no fault: go to IDLE.
    - On the last stop sample with a fault: go to WAIT_IDLE.
  - WAIT_IDLE: stay until signal=1 is sampled, then go to IDLE. No flags are raised while waiting.
- Parity check:
  - Odd mode: the count of 1s over data bits plus the parity bit must be odd.
  - Even mode: that count must be even.
  - PARITY_MODE=0: parity is never in error.
- Flag priority at frame end:
  - If stop bits are ok: valid=1 or parity_error=1 (mutually exclusive). data is loaded in both cases.
  - If a stop bit is bad: frame_error=1, valid=0, parity_error=0, data unchanged.
- Timing: latency from the start-bit sample edge to flag assertion is 1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS cycles.
- Back-to-back frames: after a good final stop bit, the FSM is in IDLE on the next edge. A start bit sampled on that edge begins the next frame with no gap required.
- data holds its value between frames. It is never cleared except by reset.
- Width: the bit counter is sized clog2(DATA_BITS+1). No wrap-around inside a frame.

Optional Feature:
Macro: UART_BREAK_DETECT_EN
- Defined:
  - Break condition: a frame in which every sampled bit is 0 (data, parity if present, and all stop bits).
  - On a break, break_det pulses instead of frame_error.
  - The FSM then goes to WAIT_IDLE, and break_det does not re-pulse until the line returns to 1.
- Not defined:
  - break_det is constant 0.
  - The same all-zero frame produces frame_error per the normal rules.

Test Plan:
1. DATA_BITS=4, PARITY_MODE=1, STOP_BITS=1. Line after idle: 0, 1,0,1,0, 1, 1 (start, data LSB first = 4'b0101, parity, stop) -> valid=1 for one cycle, data=4'h5, other flags 0.
2. Same config. Frame 0, 1,1,0,0, 1, 1 (data 4'h3, two 1s plus parity 1 = three, odd) -> valid. Then frame 0, 1,1,0,0, 0, 1 -> parity_error=1, valid=0, data=4'h3.
3. Same config. Frame 0, 1,0,1,0, 1, 0 (bad stop) -> frame_error=1, data unchanged. Line held 0 for 3 more cycles -> no further flags. Then 1, followed by a good frame -> valid.
4. Same config. Seven consecutive 0s -> break_det=1 with UART_BREAK_DETECT_EN defined, frame_error=1 without it. No repeat pulse while the line stays 0.
5. DATA_BITS=8, PARITY_MODE=2, STOP_BITS=2. Byte 8'hA5 sent back-to-back twice with correct even parity and stops 1,1 -> two valid pulses 12 cycles apart, data=8'hA5. Then a second stop bit of 0 -> frame_error.
6. Reset pulse asserted during data bit 2 of a frame -> all outputs 0 and data=0 on the next edge. Remaining bits produce no flag. The next full frame is received correctly.

Source files
------------

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: serial frame receiver and checker, one line bit per clock.
// Frame format: start(0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
// Optional build macro: UART_BREAK_DETECT_EN. When it is defined, an all-zero frame pulses
// break_det instead of frame_error.
//
// Output semantics: valid, parity_error, frame_error and break_det are registered one-cycle pulses.
// They are raised on the edge that samples the final stop bit, so at most one of them is high in any cycle.
// There is no backpressure. A pulse that is not consumed in its cycle is lost.
// data holds the payload of the last frame whose stop bits were good.
module uart_frame_rx #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 signal,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 break_det
);

    localparam int             CW        = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]  LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t               state_q, state_n;
    logic [DATA_BITS-1:0] shift_q, shift_n, data_n;
    logic [CW-1:0]        cnt_q, cnt_n;
    logic                 stop_idx_q, stop_idx_n;
    logic                 stop_bad_q, stop_bad_n;
    logic                 par_q, par_n;
    logic                 zero_q, zero_n;
    logic                 valid_n, perr_n, ferr_n, brk_n;
    logic                 fault, parity_ok, is_break;

    // Register the state, the datapath and the output pulses. Reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            stop_idx_q   <= 1'b0;
            stop_bad_q   <= 1'b0;
            par_q        <= 1'b0;
            zero_q       <= 1'b0;
            data         <= '0;
            valid        <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            state_q      <= state_n;
            shift_q      <= shift_n;
            cnt_q        <= cnt_n;
            stop_idx_q   <= stop_idx_n;
            stop_bad_q   <= stop_bad_n;
            par_q        <= par_n;
            zero_q       <= zero_n;
            data         <= data_n;
            valid        <= valid_n;
            parity_error <= perr_n;
            frame_error  <= ferr_n;
            break_det    <= brk_n;
        end
    end

    // Next-state logic, bit capture, and the end-of-frame verdict.
    always_comb begin
        state_n    = state_q;
        shift_n    = shift_q;
        cnt_n      = cnt_q;
        stop_idx_n = stop_idx_q;
        stop_bad_n = stop_bad_q;
        par_n      = par_q;
        zero_n     = zero_q;
        data_n     = data;
        valid_n    = 1'b0;
        perr_n     = 1'b0;
        ferr_n     = 1'b0;
        brk_n      = 1'b0;

        // The fault covers any earlier bad stop bit and the stop bit being sampled now.
        fault     = stop_bad_q | ~signal;
        parity_ok = 1'b1;
        if (PARITY_MODE == 1) begin
            parity_ok = (^shift_q) ^ par_q;
        end else if (PARITY_MODE == 2) begin
            parity_ok = ~((^shift_q) ^ par_q);
        end
        is_break = 1'b0;
`ifdef UART_BREAK_DETECT_EN
        is_break = zero_q & ~signal;
`endif

        case (state_q)
            IDLE: begin
                if (!signal) begin
                    state_n    = DATA;
                    shift_n    = '0;
                    cnt_n      = '0;
                    stop_idx_n = 1'b0;
                    stop_bad_n = 1'b0;
                    par_n      = 1'b0;
                    zero_n     = 1'b1;
                end
            end
            DATA: begin
                shift_n                = shift_q >> 1;
                shift_n[DATA_BITS-1]   = signal;
                zero_n                 = zero_q & ~signal;
                cnt_n                  = cnt_q + 1'b1;
                if (cnt_q == LAST_DATA) begin
                    state_n = (PARITY_MODE != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_n   = signal;
                zero_n  = zero_q & ~signal;
                state_n = STOP;
            end
            STOP: begin
                zero_n     = zero_q & ~signal;
                stop_bad_n = fault;
                if (stop_idx_q == LAST_STOP) begin
                    if (fault) begin
                        state_n = WAIT_IDLE;
                        if (is_break) begin
                            brk_n = 1'b1;
                        end else begin
                            ferr_n = 1'b1;
                        end
                    end else begin
                        state_n = IDLE;
                        data_n  = shift_q;
                        if (parity_ok) begin
                            valid_n = 1'b1;
                        end else begin
                            perr_n = 1'b1;
                        end
                    end
                end else begin
                    stop_idx_n = stop_idx_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (signal) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
